// File: rtl/sipo_frame_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver state encoding, parity-mode codes and counter sizing.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rxState_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Bit counter must hold 0..dataW.
    function automatic int cntWidth(input int dataW);
        return $clog2(dataW + 1);
    endfunction

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Serial line, enable and frame-result signals between line driver and receiver.
// The master drives the line; the slave (the receiver) returns the frame result.
interface sipo_frame_rx_if #(
    parameter int DATA_W = 8
);

    logic              DataTx;
    logic              Recieve;
    logic [DATA_W-1:0] DataParl;
    logic              RecievedFlag;
    logic              ParityError;
    logic              StopError;
    logic              Busy;

    modport master (
        output DataTx,
        output Recieve,
        input  DataParl,
        input  RecievedFlag,
        input  ParityError,
        input  StopError,
        input  Busy
    );

    modport slave (
        input  DataTx,
        input  Recieve,
        output DataParl,
        output RecievedFlag,
        output ParityError,
        output StopError,
        output Busy
    );

endinterface

// File: rtl/sipo_frame_rx_parity_check.sv
// Running XOR of the data bits, compared against the received parity bit.
// The error output is combinational so the caller can capture it on the parity edge.
module rx_parity_check
    import uart_rx_pkg::*;
#(
    parameter int MODE = PAR_NONE
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic dataBit,
    input  logic parityBit,
    output logic parityErr
);

    logic acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ dataBit;
        end
    end

    always_comb begin
        parityErr = 1'b0;
        if (MODE == PAR_ODD) begin
            parityErr = ((acc ^ parityBit) != 1'b1);
        end else if (MODE == PAR_EVEN) begin
            parityErr = ((acc ^ parityBit) != 1'b0);
        end
    end

endmodule

// File: rtl/sipo_frame_rx.sv
// Parametrised UART frame receiver: detects the start bit, shifts in the payload,
// checks parity and stop bits, and publishes the payload with error flags.
module sipo_frame_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int LSB_FIRST   = 1
) (
    input  logic          BaudOut,
    input  logic          Reset,
    sipo_frame_rx_if.slave rx
);

    // state  | meaning
    // IDLE   | waiting for a low start bit while Recieve is high
    // DATA   | shifting in DATA_W payload bits
    // PARITY | sampling the parity bit (only when PARITY_MODE != 0)
    // STOP   | sampling STOP_BITS stop bits; last one completes the frame

    localparam int CNT_W = cntWidth(DATA_W);

    if (DATA_W < 5 || DATA_W > 9) begin : gBadDataW
        $fatal(1, "sipo_frame_rx: DATA_W must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : gBadParity
        $fatal(1, "sipo_frame_rx: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStop
        $fatal(1, "sipo_frame_rx: STOP_BITS must be 1 or 2");
    end
    if (LSB_FIRST < 0 || LSB_FIRST > 1) begin : gBadOrder
        $fatal(1, "sipo_frame_rx: LSB_FIRST must be 0 or 1");
    end

    rxState_t          state;
    rxState_t          stateNext;
    logic [CNT_W-1:0]  bitCnt;
    logic [DATA_W-1:0] shiftReg;
    logic [DATA_W-1:0] shiftNext;
    logic              parErrPend;
    logic              stopErrPend;
    logic              startSeen;
    logic              lastData;
    logic              lastStop;
    logic              accEn;
    logic              parityErr;

    always_ff @(posedge BaudOut) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        startSeen = 1'b0;
        lastData  = 1'b0;
        lastStop  = 1'b0;
        if (state != IDLE && !rx.Recieve) begin
            // Enable dropped mid-frame: discard everything collected so far.
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rx.Recieve && !rx.DataTx) begin
                        startSeen = 1'b1;
                        stateNext = DATA;
                    end
                end
                DATA: begin
                    if (bitCnt == CNT_W'(DATA_W - 1)) begin
                        lastData  = 1'b1;
                        stateNext = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    stateNext = STOP;
                end
                STOP: begin
                    if (bitCnt == CNT_W'(STOP_BITS - 1)) begin
                        lastStop  = 1'b1;
                        stateNext = IDLE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    assign accEn = (state == DATA) && rx.Recieve;

    always_comb begin
        if (LSB_FIRST != 0) begin
            shiftNext = {rx.DataTx, shiftReg[DATA_W-1:1]};
        end else begin
            shiftNext = {shiftReg[DATA_W-2:0], rx.DataTx};
        end
    end

    rx_parity_check #(
        .MODE (PARITY_MODE)
    ) uParity (
        .clk       (BaudOut),
        .rst       (Reset),
        .clr       (startSeen),
        .en        (accEn),
        .dataBit   (rx.DataTx),
        .parityBit (rx.DataTx),
        .parityErr (parityErr)
    );

    always_ff @(posedge BaudOut) begin
        if (Reset) begin
            bitCnt          <= '0;
            shiftReg        <= '0;
            parErrPend      <= 1'b0;
            stopErrPend     <= 1'b0;
            rx.DataParl     <= '0;
            rx.RecievedFlag <= 1'b0;
            rx.ParityError  <= 1'b0;
            rx.StopError    <= 1'b0;
        end else begin
            rx.RecievedFlag <= 1'b0;
            if (startSeen) begin
                bitCnt      <= '0;
                shiftReg    <= '0;
                parErrPend  <= 1'b0;
                stopErrPend <= 1'b0;
            end else if (state == DATA && rx.Recieve) begin
                shiftReg <= shiftNext;
                // Clearing on the last data bit makes STOP start from zero.
                bitCnt   <= lastData ? '0 : bitCnt + 1'b1;
            end else if (state == PARITY && rx.Recieve) begin
                parErrPend <= parityErr;
            end else if (state == STOP && rx.Recieve) begin
                bitCnt      <= lastStop ? '0 : bitCnt + 1'b1;
                stopErrPend <= stopErrPend | ~rx.DataTx;
                if (lastStop) begin
                    rx.DataParl     <= shiftReg;
                    rx.ParityError  <= (PARITY_MODE != PAR_NONE) && parErrPend;
                    rx.StopError    <= stopErrPend | ~rx.DataTx;
                    rx.RecievedFlag <= 1'b1;
                end
            end
        end
    end

    assign rx.Busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed and random frames across several receiver configurations,
// checked against a frame-level model of the serial format.
module tb_sipo_frame_rx;

    localparam int NCFG = 6;
    localparam int CW[NCFG] = '{8, 8, 8, 7, 9, 5};
    localparam int CP[NCFG] = '{0, 1, 0, 2, 2, 1};
    localparam int CS[NCFG] = '{1, 1, 2, 1, 2, 1};
    localparam int CL[NCFG] = '{1, 1, 1, 0, 1, 0};

    logic clk = 1'b0;
    logic rst;
    logic lineTx [NCFG];
    logic rcv    [NCFG];

    logic [NCFG-1:0] obsBusy;
    logic [NCFG-1:0] obsFlag;
    logic [NCFG-1:0] obsPe;
    logic [NCFG-1:0] obsSe;
    logic [8:0]      obsData [NCFG];

    int nChecks = 0;
    int nFail   = 0;
    int edgeNo  = 0;

    logic [8:0] mData [NCFG];
    logic       mPe   [NCFG];
    logic       mSe   [NCFG];
    int         lastFlagEdge [NCFG];

    always #5 clk = ~clk;
    always @(posedge clk) edgeNo <= edgeNo + 1;

    for (genvar g = 0; g < NCFG; g++) begin : gCfg
        sipo_frame_rx_if #(.DATA_W(CW[g])) bus ();
        assign bus.DataTx  = lineTx[g];
        assign bus.Recieve = rcv[g];
        sipo_frame_rx #(
            .DATA_W      (CW[g]),
            .PARITY_MODE (CP[g]),
            .STOP_BITS   (CS[g]),
            .LSB_FIRST   (CL[g])
        ) dut (
            .BaudOut (clk),
            .Reset   (rst),
            .rx      (bus)
        );
        assign obsBusy[g] = bus.Busy;
        assign obsFlag[g] = bus.RecievedFlag;
        assign obsPe[g]   = bus.ParityError;
        assign obsSe[g]   = bus.StopError;
        assign obsData[g] = 9'(bus.DataParl);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkHeld(input int d, input string where);
        chk({where, " busy"}, 32'(obsBusy[d]), 32'(1'b0));
        chk({where, " flag"}, 32'(obsFlag[d]), 32'(1'b0));
        chk({where, " data hold"}, 32'(obsData[d]), 32'(mData[d]));
    endtask

    task automatic checkAllReset();
        for (int d = 0; d < NCFG; d++) begin
            mData[d] = '0;
            mPe[d]   = 1'b0;
            mSe[d]   = 1'b0;
            chk($sformatf("reset busy c%0d", d), 32'(obsBusy[d]), 0);
            chk($sformatf("reset flag c%0d", d), 32'(obsFlag[d]), 0);
            chk($sformatf("reset data c%0d", d), 32'(obsData[d]), 0);
            chk($sformatf("reset perr c%0d", d), 32'(obsPe[d]), 0);
            chk($sformatf("reset serr c%0d", d), 32'(obsSe[d]), 0);
        end
    endtask

    task automatic idle(input int d, input int n);
        lineTx[d] = 1'b1;
        rcv[d]    = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            checkHeld(d, $sformatf("idle c%0d", d));
        end
    endtask

    function automatic logic dataBitAt(input int d, input logic [8:0] p, input int i);
        return (CL[d] != 0) ? p[i] : p[CW[d] - 1 - i];
    endfunction

    // Start bit plus the first nb payload bits, then leaves the frame open.
    task automatic sendBits(input int d, input logic [8:0] payload, input int nb);
        rcv[d] = 1'b1;
        for (int k = 0; k <= nb; k++) begin
            lineTx[d] = (k == 0) ? 1'b0 : dataBitAt(d, payload, k - 1);
            tick();
            chk($sformatf("partial busy c%0d", d), 32'(obsBusy[d]), 1);
            chk($sformatf("partial flag c%0d", d), 32'(obsFlag[d]), 0);
        end
    endtask

    task automatic sendFrame(input int d, input logic [8:0] payload, input bit badPar,
                             input logic [1:0] stopMask, input int expGap);
        logic       bits[$];
        logic [8:0] p;
        logic [1:0] sm;
        logic       par;
        logic       expPe;
        logic       expSe;
        int         ones;
        int         n;
        p    = payload & 9'((1 << CW[d]) - 1);
        sm   = stopMask & 2'((1 << CS[d]) - 1);
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < CW[d]; i++) bits.push_back(dataBitAt(d, p, i));
        if (CP[d] != 0) begin
            ones = $countones(p);
            par  = (CP[d] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
            bits.push_back(badPar ? ~par : par);
        end
        for (int s = 0; s < CS[d]; s++) bits.push_back(~sm[s]);
        expPe = badPar && (CP[d] != 0);
        expSe = (sm != 2'b00);
        n     = bits.size();
        rcv[d] = 1'b1;
        for (int k = 0; k < n; k++) begin
            lineTx[d] = bits[k];
            tick();
            if (k < n - 1) begin
                chk($sformatf("busy e%0d c%0d", k + 1, d), 32'(obsBusy[d]), 1);
                chk($sformatf("flag e%0d c%0d", k + 1, d), 32'(obsFlag[d]), 0);
                chk($sformatf("data hold e%0d c%0d", k + 1, d), 32'(obsData[d]), 32'(mData[d]));
            end else begin
                chk($sformatf("done busy c%0d", d), 32'(obsBusy[d]), 0);
                chk($sformatf("done flag c%0d", d), 32'(obsFlag[d]), 1);
                chk($sformatf("done data c%0d", d), 32'(obsData[d]), 32'(p));
                chk($sformatf("done perr c%0d", d), 32'(obsPe[d]), 32'(expPe));
                chk($sformatf("done serr c%0d", d), 32'(obsSe[d]), 32'(expSe));
                if (expGap > 0)
                    chk($sformatf("flag spacing c%0d", d), 32'(edgeNo - lastFlagEdge[d]), 32'(expGap));
                lastFlagEdge[d] = edgeNo;
                mData[d] = p;
                mPe[d]   = expPe;
                mSe[d]   = expSe;
            end
        end
        lineTx[d] = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < NCFG; d++) begin
            lineTx[d]       = 1'b1;
            rcv[d]          = 1'b0;
            lastFlagEdge[d] = 0;
        end
        repeat (3) tick();
        checkAllReset();
        rst = 1'b0;

        // 8N1 LSB-first: line 0,1,0,1,0,0,1,0,1,1 carries 0xA5
        sendFrame(0, 9'h0A5, 1'b0, 2'b00, 0);
        idle(0, 2);

        // 8O1: good then bad parity
        sendFrame(1, 9'h055, 1'b0, 2'b00, 0);
        idle(1, 1);
        sendFrame(1, 9'h055, 1'b1, 2'b00, 0);
        idle(1, 1);

        // 8N2: second stop low, then a clean frame clears the error
        sendFrame(2, 9'h05A, 1'b0, 2'b10, 0);
        idle(2, 1);
        sendFrame(2, 9'h03C, 1'b0, 2'b00, 0);
        idle(2, 1);

        // Enable dropped after four data bits
        sendBits(0, 9'h0F0, 4);
        rcv[0]    = 1'b0;
        lineTx[0] = 1'b1;
        tick();
        checkHeld(0, "abort");
        idle(0, 3);

        // Low line ignored while disabled; start taken as soon as enable rises
        rcv[0]    = 1'b0;
        lineTx[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkHeld(0, "disabled low");
        end
        sendFrame(0, 9'h0C3, 1'b0, 2'b00, 0);
        idle(0, 1);

        // Reset mid-frame clears every receiver
        sendBits(1, 9'h033, 3);
        rst       = 1'b1;
        lineTx[1] = 1'b0;
        tick();
        checkAllReset();
        rst       = 1'b0;
        lineTx[1] = 1'b1;
        idle(1, 1);
        sendFrame(0, 9'h081, 1'b0, 2'b00, 0);
        idle(0, 1);

        // 7E1 MSB-first back-to-back: flags exactly 10 edges apart
        sendFrame(3, 9'h012, 1'b0, 2'b00, 0);
        sendFrame(3, 9'h06D, 1'b0, 2'b00, 10);
        idle(3, 2);

        // Random frames on every configuration
        for (int d = 0; d < NCFG; d++) begin
            for (int r = 0; r < 6; r++) begin
                logic [8:0] pay;
                bit         bp;
                logic [1:0] sm;
                int         gap;
                pay = 9'($urandom);
                bp  = (CP[d] != 0) && ($urandom_range(0, 3) == 0);
                sm  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                sendFrame(d, pay, bp, sm, 0);
                gap = $urandom_range(0, 2);
                if (gap > 0) idle(d, gap);
            end
            idle(d, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Parametrised serial-in/parallel-out frame receiver for the UART-Rx path. It is the successor to the fixed 11-bit SIPO.
- Detects the start bit itself instead of shifting blindly.
- Supports configurable data width, parity mode, stop-bit count and bit order.
- Checks parity and stop bits, and delivers only the data payload with error flags.
- Samples one line bit per `BaudOut` rising edge; sits between the baud generator and the Rx output register.

## Interface
Parameters:
- `DATA_W`, 8, payload bits per frame; legal 5..9.
- `PARITY_MODE`, 0, 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits per frame; legal 1 or 2.
- `LSB_FIRST`, 1, 1 = first data bit lands in `DataParl[0]`; 0 = first data bit lands in `DataParl[DATA_W-1]`.

Ports:
- `BaudOut`, in, 1, sole clock; one line sample per rising edge.
- `Reset`, in, 1, synchronous, active-high reset; sampled on `BaudOut` rising edge.
- `DataTx`, in, 1, serial line; idles high.
- `Recieve`, in, 1, receive enable; low aborts any frame in progress.
- `DataParl`, out, `DATA_W`, last completed payload.
- `RecievedFlag`, out, 1, one-cycle pulse when a frame completes.
- `ParityError`, out, 1, parity mismatch in last completed frame; always 0 when `PARITY_MODE`=0.
- `StopError`, out, 1, at least one stop bit sampled low in last completed frame.
- `Busy`, out, 1, high whenever state ≠ IDLE.

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - `Recieve`=1 and `DataTx`=0 sampled → go to DATA, clear the bit counter and shift register.
  - `DataTx`=1 or `Recieve`=0 → stay in IDLE.
- DATA:
  - Shift in `DataTx` once per edge, for `DATA_W` edges total.
  - Accumulate XOR of the data bits.
  - After the last data bit → go to PARITY if `PARITY_MODE`≠0, else STOP.
- PARITY: sample one bit.
  - Error if data XOR ^ parity bit ≠ 1 (odd mode).
  - Error if data XOR ^ parity bit ≠ 0 (even mode).
  - → STOP.
- STOP:
  - Sample `STOP_BITS` bits; any 0 sets the pending stop error.
  - After the last stop bit → IDLE.
  - On that same edge: load `DataParl`, `ParityError` and `StopError`, and set `RecievedFlag`.
- A frame with a stop or parity error still completes: `RecievedFlag` pulses and `DataParl` is updated.
- `DataParl`, `ParityError` and `StopError` hold their values until the next frame completes.
- `Recieve`=0 sampled in any non-IDLE state:
  - → IDLE on that edge, partial frame discarded.
  - No flag; outputs unchanged.
- `Reset`=1 takes priority over everything, including mid-frame.
  - State → IDLE; counters cleared.
  - `DataParl`=0, `RecievedFlag`=0, `ParityError`=0, `StopError`=0, `Busy`=0.
- Bit counter is sized ceil(log2(`DATA_W`+1)). Wrap-around is never used; the counter is cleared on every entry to DATA and STOP.

## Timing
- Frame length N = 1 + `DATA_W` + (`PARITY_MODE`≠0) + `STOP_BITS` edges; edge 1 samples the start bit.
- Outputs update on edge N. `RecievedFlag` is high from edge N to edge N+1, exactly one cycle.
- `Busy` rises after edge 1 and falls after edge N.
- Back-to-back frames: a start bit sampled on edge N+1 is accepted, so a zero idle gap is supported.
- A low on `DataTx` while `Recieve`=0 is ignored.
- If `Recieve` rises while `DataTx` is already low, the start is taken on the first edge where both conditions hold.

## Structure
- Shared package `uart_rx_pkg`:
  - state enum (IDLE, DATA, PARITY, STOP);
  - parity-mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`.
- One sub-module, `rx_parity_check`: running-XOR accumulator with clear/enable and a mode-dependent error output.
- Parameter legality is checked at elaboration; illegal values are a fatal error.

## Test plan
- 8N1, LSB-first, line 0,1,0,1,0,0,1,0,1,1 → after edge 10: `DataParl`=0xA5, `RecievedFlag` for 1 cycle, `ParityError`=0, `StopError`=0.
- `DATA_W`=8, odd parity, payload 0x55 (four ones):
  - parity bit 1 → `ParityError`=0;
  - repeat with parity bit 0 → `ParityError`=1, `DataParl`=0x55, flag still pulses.
- 8N2, second stop bit driven 0 → `StopError`=1 on completion. Next clean frame 0x3C clears it: `StopError`=0, `DataParl`=0x3C.
- `Recieve` dropped after 4 data bits, then restored with line idle → `Busy` falls next edge, no `RecievedFlag`, `DataParl` keeps its prior value.
- `Reset` pulsed mid-frame → all outputs 0 next edge. A following full frame 0x81 is received correctly.
- Two 7E1 frames 0x12, 0x6D, MSB-first, zero idle gap → two flag pulses exactly 10 edges apart, values 0x12 then 0x6D.
